alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Execute-stage initiator for the 64-bit ALU. Accepts a decoded instruction (operands, funct fields, main-control
//  ALU class) over a valid/ready handshake, derives the 4-bit ALU opcode, drives the ALU's a/b/op inputs, captures
//  result/zero/bne/bgt, resolves branches and returns result + branch decision to writeback/PC logic.
// PARAMETERS
//  XLEN   64  operand/result width
//  PC_W   64  program-counter width
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high
//  in_valid     in   1      instruction fields valid
//  in_ready     out  1      block can accept
//  alu_class    in   2      00 load/store (add), 01 branch (sub), 10 R/I-type (funct-decoded), 11 reserved
//  funct3       in   3      instruction funct3
//  funct7_b5    in   1      instruction bit 30
//  use_imm      in   1      1: B operand = imm, 0: B operand = rs2_data
//  rs1_data     in   XLEN   A operand
//  rs2_data     in   XLEN   register B operand
//  imm          in   XLEN   sign-extended immediate
//  pc           in   PC_W   instruction PC
//  alu_a        out  XLEN   to ALU a
//  alu_b        out  XLEN   to ALU b
//  alu_op       out  4      to ALU ALUop
//  alu_result   in   XLEN   from ALU (combinational)
//  alu_zero     in   1      from ALU
//  alu_bne      in   1      from ALU
//  alu_bgt      in   1      from ALU (a > b, unsigned)
//  out_valid    out  1      result/branch valid
//  out_ready    in   1      consumer accepts
//  out_result   out  XLEN   captured ALU result
//  out_zero     out  1      captured zero flag
//  branch_taken out  1      branch decision (0 unless alu_class=01)
//  branch_target out PC_W   pc + (imm << 1), truncated to PC_W
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; alu_a/alu_b/out_result=0; alu_op=4'b0000;
//    out_zero=0; branch_taken=0; branch_target=0. In-flight op dropped, never emitted.
//  - FSM: IDLE -> EXEC on in_valid&in_ready (operands, pc, class, funct registered); EXEC -> DONE unconditionally
//    (ALU outputs sampled at end of EXEC); DONE -> DONE while !out_ready; DONE -> IDLE on out_ready&!in_valid;
//    DONE -> EXEC on out_ready&in_valid (new op accepted same cycle).
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). Latency accept->out_valid = 2 cycles; max 1 op / 2 cycles.
//  - alu_a/alu_b/alu_op are registered, stable from EXEC through DONE; outputs hold while out_valid & !out_ready.
//  - Opcode decode: class 00 -> 0010; class 01 -> 0110; class 11 -> 1111 (nor);
//    class 10: funct3 000 -> 0110 if funct7_b5 & !use_imm else 0010; 111 -> 0000; 110 -> 0001; other -> 1111.
//  - Branch (class 01, funct3): 000 taken=zero; 001 taken=bne; 101 taken=bgt|zero; 100 taken=!bgt&!zero;
//    other funct3 -> taken=0. Non-branch classes: branch_taken=0, branch_target still computed.
//  - Arithmetic wraps modulo 2^XLEN / 2^PC_W; imm<<1 discards the top bit; no overflow flag.
//  - out_valid deasserts only after handshake; in_valid while busy is ignored (no capture, in_ready=0).
// STRUCTURE
//  - Shared package alu_defs_pkg: ALU opcode localparams (AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1111),
//    alu_class codes, branch funct3 codes, FSM state encoding.
//  - One sub-module natural: alu_op_decode (combinational class/funct3/funct7_b5/use_imm -> 4-bit op).
//  - ALU itself instantiated outside, at the parent level.
// TESTING
//  - R-type add: rs1=5, rs2=7, class 10, funct3 000, b5=0 -> alu_op 0010, out_result=12, out_zero=0, 2 cycles after accept.
//  - R-type sub to zero: rs1=rs2=64'h1234, b5=1 -> alu_op 0110, out_result=0, out_zero=1, branch_taken=0.
//  - BEQ/BNE: class 01, rs1=rs2=9, pc=0x100, imm=8: funct3 000 -> taken=1, target=0x110; funct3 001 -> taken=0.
//  - BLT/BGE: rs1=3, rs2=10: funct3 100 -> taken=1; funct3 101 -> taken=0; swap operands -> reversed.
//  - Backpressure: hold out_ready=0 5 cycles -> outputs stable, in_ready=0; then out_ready=1 & in_valid=1 -> next op accepted that cycle.
//  - Reset in EXEC with in-flight add -> next cycle all outputs 0, in_ready=1, no out_valid pulse after release.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue controller.
//   - ALU opcode encodings driven on alu_op
//   - main-control ALU class codes
//   - funct3 codes used by the opcode decode and branch resolution
//   - controller FSM state encoding
package alu_defs_pkg;

    localparam int XLEN_DEF = 64;
    localparam int PC_W_DEF = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1111;

    localparam logic [1:0] CLS_MEM    = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_ARITH  = 2'b10;
    localparam logic [1:0] CLS_RSVD   = 2'b11;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU opcode decode.
// Ports:
//   alu_class  in  2  main-control ALU class
//   funct3     in  3  instruction funct3
//   funct7_b5  in  1  instruction bit 30
//   use_imm    in  1  B operand comes from the immediate
//   alu_op     out 4  opcode for the ALU
module alu_op_decode
    import alu_defs_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       use_imm,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_NOR;
        case (alu_class)
            CLS_MEM:    alu_op = ALU_ADD;
            CLS_BRANCH: alu_op = ALU_SUB;
            CLS_ARITH: begin
                case (funct3)
                    // bit 30 only selects sub for register-register forms;
                    // for addi it is part of the immediate
                    F3_ADD:  alu_op = (funct7_b5 && !use_imm) ? ALU_SUB : ALU_ADD;
                    F3_AND:  alu_op = ALU_AND;
                    F3_OR:   alu_op = ALU_OR;
                    default: alu_op = ALU_NOR;
                endcase
            end
            default:    alu_op = ALU_NOR;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage initiator for an external 64-bit ALU.
// Accepts a decoded instruction over valid/ready, registers the ALU a/b/op
// inputs, samples the ALU outputs one cycle later, resolves branches and
// presents the result over a second valid/ready handshake.
// Ports:
//   clk, reset                          clock, async active-high reset
//   in_valid/in_ready                   instruction handshake
//   alu_class, funct3, funct7_b5,
//   use_imm, rs1_data, rs2_data,
//   imm, pc                             instruction fields
//   alu_a, alu_b, alu_op                registered drive to the ALU
//   alu_result, alu_zero, alu_bne,
//   alu_bgt                             ALU outputs (combinational)
//   out_valid/out_ready                 result handshake
//   out_result, out_zero,
//   branch_taken, branch_target         captured result and branch decision
module alu_issue_ctrl
    import alu_defs_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_class,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic            use_imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [PC_W-1:0] pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_bne,
    input  logic            alu_bgt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            branch_taken,
    output logic [PC_W-1:0] branch_target
);

    state_t          state;
    logic [1:0]      class_q;
    logic [2:0]      funct3_q;
    logic [PC_W-1:0] target_q;
    logic [3:0]      op_dec;
    logic            accept;
    logic            taken;
    logic [XLEN-1:0] imm_shl;
    logic [PC_W-1:0] target_next;

    alu_op_decode u_dec (
        .alu_class (alu_class),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .use_imm   (use_imm),
        .alu_op    (op_dec)
    );

    assign in_ready    = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept      = in_valid && in_ready;
    assign imm_shl     = {imm[XLEN-2:0], 1'b0};
    assign target_next = pc + PC_W'(imm_shl);

    // Branch resolution from the flags of the a-b subtraction issued in EXEC.
    always_comb begin
        taken = 1'b0;
        if (class_q == CLS_BRANCH) begin
            case (funct3_q)
                F3_BEQ:  taken = alu_zero;
                F3_BNE:  taken = alu_bne;
                F3_BGE:  taken = alu_bgt || alu_zero;
                F3_BLT:  taken = !alu_bgt && !alu_zero;
                default: taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            class_q       <= CLS_MEM;
            funct3_q      <= 3'b000;
            target_q      <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= ALU_AND;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_zero      <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            if (accept) begin
                alu_a    <= rs1_data;
                alu_b    <= use_imm ? imm : rs2_data;
                alu_op   <= op_dec;
                class_q  <= alu_class;
                funct3_q <= funct3;
                target_q <= target_next;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    out_result    <= alu_result;
                    out_zero      <= alu_zero;
                    branch_taken  <= taken;
                    branch_target <= target_q;
                    out_valid     <= 1'b1;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_class;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        use_imm;
    logic [63:0] rs1_data, rs2_data, imm, pc;
    logic [63:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic        alu_zero, alu_bne, alu_bgt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_zero;
    logic        branch_taken;
    logic [63:0] branch_target;

    alu_issue_ctrl #(.XLEN(64), .PC_W(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_class(alu_class), .funct3(funct3), .funct7_b5(funct7_b5), .use_imm(use_imm),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_bne(alu_bne), .alu_bgt(alu_bgt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1111: alu_result = ~(alu_a | alu_b);
            default: alu_result = 64'd0;
        endcase
        alu_zero = (alu_result == 64'd0);
        alu_bne  = (alu_a != alu_b);
        alu_bgt  = (alu_a > alu_b);
    end

    typedef struct {
        logic [63:0] a, b;
        logic [3:0]  op;
        logic [63:0] result;
        logic        zero;
        logic        taken;
        logic [63:0] target;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
    bit   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] cls, input logic [2:0] f3, input logic b5,
                                   input logic ui, input logic [63:0] a, input logic [63:0] r2,
                                   input logic [63:0] im, input logic [63:0] pcv);
        exp_t e;
        logic [63:0] b;
        b = ui ? im : r2;
        e.a = a;
        e.b = b;
        if (cls == 2'd0)      e.op = 4'b0010;
        else if (cls == 2'd1) e.op = 4'b0110;
        else if (cls == 2'd3) e.op = 4'b1111;
        else if (f3 == 3'd0)  e.op = (b5 && !ui) ? 4'b0110 : 4'b0010;
        else if (f3 == 3'd7)  e.op = 4'b0000;
        else if (f3 == 3'd6)  e.op = 4'b0001;
        else                  e.op = 4'b1111;
        case (e.op)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0010: e.result = a + b;
            4'b0110: e.result = a - b;
            default: e.result = ~(a | b);
        endcase
        e.zero  = (e.result == 64'd0);
        e.taken = 1'b0;
        if (cls == 2'd1) begin
            if (f3 == 3'd0)      e.taken = (a == b);
            else if (f3 == 3'd1) e.taken = (a != b);
            else if (f3 == 3'd5) e.taken = (a >= b);
            else if (f3 == 3'd4) e.taken = (a < b);
        end
        e.target = pcv + (im * 64'd2);
        e.acc = 0;
        return e;
    endfunction

    // Caller is just after a rising edge; returns the edge number of acceptance.
    task automatic issue(input logic [1:0] cls, input logic [2:0] f3, input logic b5, input logic ui,
                         input logic [63:0] a, input logic [63:0] r2, input logic [63:0] im,
                         input logic [63:0] pcv, output int acc);
        exp_t e;
        alu_class = cls; funct3 = f3; funct7_b5 = b5; use_imm = ui;
        rs1_data = a; rs2_data = r2; imm = im; pc = pcv;
        in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge clk);
            if (in_ready) acc = cyc + 1;
        end
        if (acc < 0) begin
            checks++; failures++;
            $display("FAIL issue_timeout: in_ready never asserted");
        end else begin
            e = model(cls, f3, b5, ui, a, r2, im, pcv);
            e.acc = acc;
            @(posedge clk);
            q.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d results outstanding", q.size());
        end
        #1;
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 2) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output: out_valid with no outstanding op, result %h", out_result);
            end else begin
                if (!seen) begin
                    chk("latency", 64'(cyc), 64'(q[0].acc + 1));
                    seen = 1;
                end
                chk("alu_a", alu_a, q[0].a);
                chk("alu_b", alu_b, q[0].b);
                chk("alu_op", 64'(alu_op), 64'(q[0].op));
                chk("out_result", out_result, q[0].result);
                chk("out_zero", 64'(out_zero), 64'(q[0].zero));
                chk("branch_taken", 64'(branch_taken), 64'(q[0].taken));
                chk("branch_target", branch_target, q[0].target);
                if (!out_ready) chk("in_ready_busy", 64'(in_ready), 64'd0);
                else begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int acc, t0;
        logic [63:0] ra, rb, ri;
        logic [1:0]  rc;
        logic [2:0]  rf;

        reset = 1'b1; in_valid = 1'b0;
        alu_class = 2'd0; funct3 = 3'd0; funct7_b5 = 1'b0; use_imm = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_branch_target", branch_target, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // directed cases
        issue(2'b10, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0, acc);
        issue(2'b10, 3'b000, 1'b1, 1'b0, 64'h1234, 64'h1234, 64'd0, 64'd0, acc);
        issue(2'b01, 3'b000, 1'b0, 1'b0, 64'd9, 64'd9, 64'd8, 64'h100, acc);
        issue(2'b01, 3'b001, 1'b0, 1'b0, 64'd9, 64'd9, 64'd8, 64'h100, acc);
        issue(2'b01, 3'b100, 1'b0, 1'b0, 64'd3, 64'd10, 64'd4, 64'h200, acc);
        issue(2'b01, 3'b101, 1'b0, 1'b0, 64'd3, 64'd10, 64'd4, 64'h200, acc);
        issue(2'b01, 3'b100, 1'b0, 1'b0, 64'd10, 64'd3, 64'd4, 64'h200, acc);
        issue(2'b01, 3'b101, 1'b0, 1'b0, 64'd10, 64'd3, 64'd4, 64'h200, acc);
        issue(2'b10, 3'b000, 1'b1, 1'b1, 64'd20, 64'd1, 64'd6, 64'd0, acc);
        issue(2'b00, 3'b010, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd2,
              64'hFFFF_FFFF_FFFF_FFF0, acc);
        issue(2'b11, 3'b000, 1'b0, 1'b0, 64'h0F0F, 64'hF000, 64'd0, 64'd0, acc);
        drain();

        // backpressure: hold out_ready low, then release with a new op in the same cycle
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(2'b10, 3'b111, 1'b0, 1'b0, 64'hFF00, 64'h0FF0, 64'd0, 64'd0, acc);
        t0 = 0;
        while (!out_valid && t0 < 20) begin @(posedge clk); #1; t0++; end
        chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        rdy_mode = 2;
        out_ready = 1'b1;
        t0 = cyc;
        issue(2'b10, 3'b110, 1'b0, 1'b0, 64'hFF00, 64'h0FF0, 64'd0, 64'd0, acc);
        chk("bp_same_cycle_accept", 64'(acc), 64'(t0 + 1));
        drain();

        // reset while an add is in flight
        @(posedge clk); #1;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 64'd11, 64'd22, 64'd0, 64'd0, acc);
        reset = 1'b1;
        #1;
        chk("rexec_out_valid", 64'(out_valid), 64'd0);
        chk("rexec_in_ready", 64'(in_ready), 64'd1);
        chk("rexec_alu_a", alu_a, 64'd0);
        chk("rexec_alu_b", alu_b, 64'd0);
        chk("rexec_alu_op", 64'(alu_op), 64'd0);
        chk("rexec_out_result", out_result, 64'd0);
        q.delete();
        seen = 0;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rexec_no_pulse", 64'(out_valid), 64'd0);
        end

        // randomized traffic with random backpressure
        rdy_mode = 0;
        @(posedge clk); #1;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            rc = 2'($urandom_range(0, 3));
            rf = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = 64'($urandom_range(0, 15));
                default: rb = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0) ra = 64'($urandom_range(0, 15));
            ri = {$urandom, $urandom};
            issue(rc, rf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, ri,
                  {$urandom, $urandom}, acc);
        end
        rdy_mode = 2;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
